spi_reg_bank: RTL and testbench
===============================

# spi_reg_bank

Parametrised SPI-mode-0 peripheral: samples an external controller's serial bus in the `clk` domain and exposes a bank of `NUM_REGS` registers, each `DATA_W` bits wide, with read-back on CIPO. It replaces the fixed five-register write-only SPI peripheral. It adds:
- configurable register count and width;
- CDC synchronisation of the SPI inputs;
- exact frame-length checking;
- per-register write strobes and error reporting.

It sits between the chip pins and the output-enable/PWM control logic.

## Interface
Parameters:
- `NUM_REGS`, 5: number of registers, addresses 0..NUM_REGS-1, range 1..2^ADDR_W.
- `DATA_W`, 8: register width and data-phase bit count.
- `ADDR_W`, 7: address-phase bit count.
- `SYNC_STAGES`, 2: flops per input synchroniser, at least 2.

Ports:
- `clk`  in  1  system clock; one clock only.
- `rst_n`  in  1  reset; synchronous and active-low.
- `COPI`  in  1  serial data from controller, asynchronous.
- `nCS`  in  1  chip select, active low, asynchronous.
- `SCLK`  in  1  SPI clock, asynchronous.
- `CIPO`  out  1  serial read data; 0 when not driving.
- `CIPO_OE`  out  1  pad output enable; 1 only while selected.
- `REGS`  out  NUM_REGS*DATA_W  flattened register contents; register i occupies bits [i*DATA_W +: DATA_W].
- `WR_STROBE`  out  NUM_REGS  one-`clk` pulse on the bit of the register just written.
- `FRAME_ERR`  out  1  one-`clk` pulse when a frame is discarded.

## Operation
- Frame format, MSB first: RW bit (1 = write, 0 = read), then `ADDR_W` address bits, then `DATA_W` data bits. FRAME_LEN = 1+ADDR_W+DATA_W, which is 16 at defaults.
- `SCLK`, `nCS` and `COPI` each pass through a `SYNC_STAGES` flop chain. One further flop on synced `SCLK` and `nCS` gives edge detection: `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`.
- FSM states:
  - IDLE → SHIFT on `cs_fall`.
  - SHIFT → COMMIT on `cs_rise`.
  - COMMIT → IDLE unconditionally, after one cycle.
- In SHIFT:
  - On `sclk_rise`: shift synced `COPI` into a FRAME_LEN shift register and increment `bit_cnt`. `bit_cnt` saturates at FRAME_LEN+1, which marks overrun.
  - Reaching `cs_fall` clears `bit_cnt` and the shift register.
- Read path:
  - When `bit_cnt` reaches 1+ADDR_W and RW = 0, load the output shift register with REGS[addr], or with 0 if addr >= NUM_REGS.
  - On each following `sclk_fall`, present the next bit on `CIPO`, MSB first. The first data bit appears on the first `sclk_fall` after the last address bit.
  - On a write frame, `CIPO` holds 0.
- COMMIT rules:
  - Write: if `bit_cnt` == FRAME_LEN, RW = 1 and addr < NUM_REGS, load the target register with the data field and pulse its `WR_STROBE` bit.
  - `FRAME_ERR`: pulse when `bit_cnt` != FRAME_LEN, including short frames and overrun, or when addr >= NUM_REGS for any RW. The frame is then discarded and no register changes.
  - Read: a read frame of correct length to a valid address produces no strobe and no error.
- `CIPO_OE` = synced `nCS` low and state is SHIFT. `CIPO` is 0 whenever `CIPO_OE` is 0.
- A `cs_fall` seen in COMMIT is deferred: the FSM goes to IDLE, then immediately to SHIFT on the held-low level. Edge detection therefore also accepts the level in IDLE.

## Timing
- Reset (`rst_n` low at a `clk` edge):
  - all REGS bits, `WR_STROBE`, `FRAME_ERR`, `CIPO` and `CIPO_OE` go to 0;
  - FSM goes to IDLE, counters and synchronisers to 0, synchroniser `nCS` stages to 1.
  - Reset mid-frame aborts it with no write and no error pulse.
- Input to internal edge latency: SYNC_STAGES+1 `clk` cycles.
- Required clock ratio: SCLK high and low phases each at least SYNC_STAGES+2 `clk` periods. nCS setup/hold to the first/last SCLK edge: same minimum.
- Write latency: REGS and `WR_STROBE` update on the `clk` edge ending the COMMIT cycle, i.e. SYNC_STAGES+3 cycles after the pin-level `nCS` rise.
- `FRAME_ERR` has the same timing as `WR_STROBE`; the two are never asserted together.
- `CIPO` changes SYNC_STAGES+2 `clk` cycles after the pin-level SCLK fall.

## Structure
- Package `spi_pkg`: FSM state enum (IDLE, SHIFT, COMMIT), RW encoding constants (RW_WRITE = 1, RW_READ = 0), and a FRAME_LEN function of ADDR_W and DATA_W.
- Sub-module `spi_sync_edge`: parametrised N-stage synchroniser with rise/fall pulse outputs and a reset value parameter. It is instantiated for `SCLK` and `nCS`; `COPI` uses the synchroniser without the edge detector.

## Test plan
- Write 0x80 0xA5 (addr 0, data 0xA5): REGS[7:0] = 0xA5, `WR_STROBE` = 5'b00001 for exactly one cycle, `FRAME_ERR` = 0.
- Write addr 4 = 0x3C, then read frame 0x04 0x00: `CIPO` shifts 0x3C MSB first during the data phase, `CIPO_OE` = 1 throughout, and REGS is unchanged.
- 15-bit frame, then 17-bit frame, both writes to addr 1: `FRAME_ERR` pulses once per frame, and REGS[15:8] stays 0x00.
- Write to addr 0x10 with NUM_REGS = 5: `FRAME_ERR` pulses, no strobe, all registers unchanged; a read of addr 0x10 returns 0x00 on `CIPO`.
- Assert `rst_n` low after 8 bits of a write to addr 2 = 0xFF: no write, no error, all outputs 0. A following complete frame then writes correctly.
- Parametrised run with NUM_REGS = 16, DATA_W = 16, ADDR_W = 4: write addr 15 = 0xBEEF, then read it back as 0xBEEF; back-to-back frames with minimum nCS-high time are all committed.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register bank.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } spi_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // RW bit + address phase + data phase
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage input synchroniser with optional rise/fall pulse detection.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;

  // Metastability chain; the last stage is the usable synced level.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign sync_o = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      // One extra flop of the synced level for edge detection.
      always_ff @(posedge clk) begin
        if (!rst_n) prev_q <= RST_VAL;
        else        prev_q <= sync_o;
      end

      assign rise_o = sync_o & ~prev_q;
      assign fall_o = ~sync_o & prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral: register bank with write strobes, read-back and frame checks.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       COPI,
  input  logic                       nCS,
  input  logic                       SCLK,
  output logic                       CIPO,
  output logic                       CIPO_OE,
  output logic [NUM_REGS*DATA_W-1:0] REGS,
  output logic [NUM_REGS-1:0]        WR_STROBE,
  output logic                       FRAME_ERR
);
  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_W:0]  NREGS    = (ADDR_W+1)'(NUM_REGS);

  logic sclk_rise, sclk_fall, sclk_unused;
  logic cs_s, cs_rise, cs_fall;
  logic copi_s;
  logic [1:0] copi_edge_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(SCLK),
    .sync_o(sclk_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(nCS),
    .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d_i(COPI),
    .sync_o(copi_s), .rise_o(copi_edge_unused[0]), .fall_o(copi_edge_unused[1])
  );

  spi_state_e                         state_q, state_d;
  logic [FRAME_LEN-1:0]               sr_q, sr_d, sr_shift;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [DATA_W-1:0]                  out_q, out_d, rd_val;
  logic                               cipo_q, cipo_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
  logic [NUM_REGS-1:0]                strobe_q, strobe_d;
  logic                               err_q, err_d;

  logic              rd_rw, cm_rw, cm_addr_ok;
  logic [ADDR_W-1:0] rd_addr, cm_addr;
  logic [DATA_W-1:0] cm_data;

  // Header as it will stand once the incoming bit is shifted in.
  assign sr_shift   = {sr_q[FRAME_LEN-2:0], copi_s};
  assign rd_rw      = sr_shift[ADDR_W];
  assign rd_addr    = sr_shift[ADDR_W-1:0];
  assign cm_rw      = sr_q[FRAME_LEN-1];
  assign cm_addr    = sr_q[DATA_W +: ADDR_W];
  assign cm_data    = sr_q[DATA_W-1:0];
  assign cm_addr_ok = {1'b0, cm_addr} < NREGS;

  // Read-back mux; unmapped addresses read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == ADDR_W'(i)) rd_val = regs_q[i];
  end

  // Next-state: a held-low nCS in IDLE starts a frame, covering a cs_fall seen during COMMIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall || !cs_s) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: shift-in, read-out on SCLK fall, commit/validate after nCS rise.
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    cipo_d   = cipo_q;
    regs_d   = regs_q;
    strobe_d = '0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (state_d == SHIFT) begin
          sr_d   = '0;
          cnt_d  = '0;
          out_d  = '0;
          cipo_d = 1'b0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          sr_d = sr_shift;
          if (cnt_q != CNT_OVR) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_ADDR && rd_rw == RW_READ) out_d = rd_val;
        end else if (sclk_fall) begin
          cipo_d = out_q[DATA_W-1];
          out_d  = out_q << 1;
        end
      end
      COMMIT: begin
        cipo_d = 1'b0;
        if (cnt_q != CNT_FULL || !cm_addr_ok) begin
          err_d = 1'b1;
        end else if (cm_rw == RW_WRITE) begin
          for (int i = 0; i < NUM_REGS; i++)
            if (cm_addr == ADDR_W'(i)) begin
              regs_d[i]   = cm_data;
              strobe_d[i] = 1'b1;
            end
        end
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      cipo_q   <= 1'b0;
      regs_q   <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      cipo_q   <= cipo_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign CIPO_OE   = ~cs_s & (state_q == SHIFT);
  assign CIPO      = cipo_q & CIPO_OE;
  assign REGS      = regs_q;
  assign WR_STROBE = strobe_q;
  assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: default instance (5x8, ADDR_W 7) and wide instance (16x16, ADDR_W 4).
module tb_spi_reg_bank;
  localparam int S  = 2;
  localparam int HP = S + 3;

  logic clk = 1'b0;
  logic rst_n, sclk, copi;
  logic [1:0] ncs;

  logic cipo_a, oe_a, err_a;
  logic [39:0] regs_a;
  logic [4:0] stb_a;
  logic cipo_b, oe_b, err_b;
  logic [255:0] regs_b;
  logic [15:0] stb_b;

  always #5 clk = ~clk;

  spi_reg_bank #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(S)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .COPI(copi), .nCS(ncs[0]), .SCLK(sclk),
    .CIPO(cipo_a), .CIPO_OE(oe_a), .REGS(regs_a), .WR_STROBE(stb_a), .FRAME_ERR(err_a)
  );

  spi_reg_bank #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(S)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .COPI(copi), .nCS(ncs[1]), .SCLK(sclk),
    .CIPO(cipo_b), .CIPO_OE(oe_b), .REGS(regs_b), .WR_STROBE(stb_b), .FRAME_ERR(err_b)
  );

  logic [15:0] model [2][16];
  int exp_stb [2][16];
  int obs_stb [2][16];
  int exp_err [2];
  int obs_err [2];
  int hi_cnt [2];
  int lo_cnt [2];
  bit chk_on;
  int n_vec, n_bad;

  function automatic int nr(input int d); return d ? 16 : 5; endfunction
  function automatic int aw(input int d); return d ? 4 : 7;  endfunction
  function automatic int dw(input int d); return d ? 16 : 8; endfunction

  function automatic logic [255:0] exp_regs(input int d);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < nr(d); i++) v = v | (256'(model[d][i]) << (i * dw(d)));
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every-cycle checks against the transaction-level model; also tallies pulses.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic nc, oe, cp, er;
        logic [15:0] stb;
        logic [255:0] ra;
        nc = ncs[d];
        oe = d ? oe_b : oe_a;
        cp = d ? cipo_b : cipo_a;
        er = d ? err_b : err_a;
        stb = d ? stb_b : 16'(stb_a);
        ra = d ? regs_b : 256'(regs_a);
        if (nc) begin hi_cnt[d]++; lo_cnt[d] = 0; end
        else    begin lo_cnt[d]++; hi_cnt[d] = 0; end
        for (int i = 0; i < 16; i++) if (stb[i]) obs_stb[d][i]++;
        if (er) obs_err[d]++;
        if (chk_on) begin
          if (er || stb != 16'h0)
            chk($sformatf("pulse_excl%0d", d), 256'({er && (stb != 16'h0), $countones(stb) > 1}), 256'(0));
          if (!oe) chk($sformatf("cipo_idle%0d", d), 256'(cp), 256'(0));
          if (nc && hi_cnt[d] > S + 2) chk($sformatf("oe_off%0d", d), 256'(oe), 256'(0));
          if (!nc && lo_cnt[d] > S + 2) chk($sformatf("oe_on%0d", d), 256'(oe), 256'(1));
          if ((nc && hi_cnt[d] > S + 4) || (!nc && lo_cnt[d] > S + 4))
            chk($sformatf("regs%0d", d), ra, exp_regs(d));
        end
      end
    end
  endtask

  // Drives one frame of n bits (nominal header/data, truncated or padded with random bits).
  // abort_at >= 0 returns before that bit with nCS still low and no model update.
  task automatic frame(input int d, input int n, input logic rw, input int addr,
                       input logic [15:0] data_in, input int gap, input int abort_at,
                       output logic [15:0] rd);
    int fl;
    logic [63:0] nom;
    logic [15:0] data;
    logic ok;
    fl   = 1 + aw(d) + dw(d);
    data = (dw(d) == 16) ? data_in : (data_in & 16'h00FF);
    nom  = (64'(rw) << (fl - 1)) | (64'(addr) << dw(d)) | 64'(data);
    rd   = '0;
    ncs[d] = 1'b0;
    tick(HP);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) return;
      sclk = 1'b0;
      copi = (i < fl) ? nom[fl - 1 - i] : 1'($urandom_range(0, 1));
      tick(HP);
      if (i >= 1 + aw(d) && i < fl) rd = {rd[14:0], (d != 0) ? cipo_b : cipo_a};
      sclk = 1'b1;
      tick(HP);
    end
    sclk = 1'b0;
    tick(HP);
    ncs[d] = 1'b1;
    ok = (addr < nr(d));
    if (n == fl && !rw) begin
      if (ok) chk($sformatf("rd%0d_a%0d", d, addr), 256'(rd), 256'(model[d][addr]));
      else    chk($sformatf("rd%0d_a%0d", d, addr), 256'(rd), 256'(0));
    end
    if (n != fl || !ok) exp_err[d]++;
    else if (rw) begin
      model[d][addr] = data;
      exp_stb[d][addr]++;
    end
    tick(gap);
  endtask

  task automatic check_counts();
    tick(S + 6);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < nr(d); i++)
        chk($sformatf("stb_cnt%0d_%0d", d, i), 256'(obs_stb[d][i]), 256'(exp_stb[d][i]));
      chk($sformatf("err_cnt%0d", d), 256'(obs_err[d]), 256'(exp_err[d]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_regs_a"}, 256'(regs_a), 256'(0));
    chk({tag, "_regs_b"}, regs_b, 256'(0));
    chk({tag, "_stb"}, 256'({stb_b, stb_a}), 256'(0));
    chk({tag, "_err"}, 256'({err_b, err_a}), 256'(0));
    chk({tag, "_cipo"}, 256'({cipo_b, cipo_a}), 256'(0));
    chk({tag, "_oe"}, 256'({oe_b, oe_a}), 256'(0));
  endtask

  initial begin
    logic [15:0] rd;
    int d, n, fl, addr;
    rst_n = 1'b0; ncs = 2'b11; sclk = 1'b0; copi = 1'b0; chk_on = 1'b0;
    n_vec = 0; n_bad = 0;
    for (int k = 0; k < 2; k++) begin
      exp_err[k] = 0; obs_err[k] = 0; hi_cnt[k] = 0; lo_cnt[k] = 0;
      for (int i = 0; i < 16; i++) begin
        model[k][i] = '0; exp_stb[k][i] = 0; obs_stb[k][i] = 0;
      end
    end
    fork
      compare_loop();
      begin
        tick(90000);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    tick(4);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);
    chk_on = 1'b1;

    // Write addr 0 = 0xA5
    frame(0, 16, 1'b1, 0, 16'h00A5, 6, -1, rd);
    check_counts();
    chk("a5_reg0", 256'(regs_a[7:0]), 256'(8'hA5));
    chk("a5_strobe_cycles", 256'(obs_stb[0][0]), 256'(1));
    chk("a5_no_err", 256'(obs_err[0]), 256'(0));

    // Write addr 4 = 0x3C, read it back
    frame(0, 16, 1'b1, 4, 16'h003C, 6, -1, rd);
    frame(0, 16, 1'b0, 4, 16'h0000, 6, -1, rd);
    check_counts();
    chk("rd_3c", 256'(rd), 256'(16'h003C));
    chk("rd_no_change", 256'(regs_a), 256'(40'h3C_0000_00A5));

    // 15- and 17-bit writes to addr 1
    frame(0, 15, 1'b1, 1, 16'h0077, 6, -1, rd);
    frame(0, 17, 1'b1, 1, 16'h0077, 6, -1, rd);
    check_counts();
    chk("len_err_pulses", 256'(obs_err[0]), 256'(2));
    chk("len_reg1_zero", 256'(regs_a[15:8]), 256'(0));

    // Out-of-range address 0x10
    frame(0, 16, 1'b1, 16, 16'h0099, 6, -1, rd);
    frame(0, 16, 1'b0, 16, 16'h0000, 6, -1, rd);
    check_counts();
    chk("bad_addr_rd", 256'(rd), 256'(0));
    chk("bad_addr_err", 256'(obs_err[0]), 256'(4));
    chk("bad_addr_regs", 256'(regs_a), 256'(40'h3C_0000_00A5));

    // Reset after 8 bits of a write to addr 2
    frame(0, 16, 1'b1, 2, 16'h00FF, 6, 8, rd);
    chk_on = 1'b0;
    rst_n = 1'b0;
    tick(1);
    ncs = 2'b11;
    sclk = 1'b0;
    tick(S + 4);
    check_all_zero("midrst");
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) model[k][i] = '0;
    rst_n = 1'b1;
    tick(S + 4);
    chk_on = 1'b1;
    chk("midrst_no_err", 256'(obs_err[0]), 256'(4));
    chk("midrst_no_stb", 256'(obs_stb[0][2]), 256'(0));
    frame(0, 16, 1'b1, 2, 16'h005A, 6, -1, rd);
    check_counts();
    chk("post_rst_reg2", 256'(regs_a[23:16]), 256'(8'h5A));

    // Wide instance: 0xBEEF round trip, then back-to-back writes at minimum gap
    frame(1, 21, 1'b1, 15, 16'hBEEF, S + 2, -1, rd);
    frame(1, 21, 1'b0, 15, 16'h0000, S + 2, -1, rd);
    check_counts();
    chk("beef_rd", 256'(rd), 256'(16'hBEEF));
    chk("beef_reg15", 256'(regs_b[255:240]), 256'(16'hBEEF));
    for (int k = 0; k < 8; k++)
      frame(1, 21, 1'b1, 2 * k, 16'($urandom), S + 2, -1, rd);
    check_counts();

    // Randomised frames on both instances
    for (int k = 0; k < 40; k++) begin
      d  = int'($urandom_range(0, 1));
      fl = 1 + aw(d) + dw(d);
      n  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, fl + 3)) : fl;
      if (d == 0) addr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 4));
      else        addr = int'($urandom_range(0, 15));
      frame(d, n, 1'($urandom_range(0, 1)), addr, 16'($urandom), int'($urandom_range(S + 2, S + 8)), -1, rd);
    end
    check_counts();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
